tick_ctrl: RTL and testbench

TICK_CTRL -- requirements
Module: tick_ctrl

---
 rtl/tick_pkg.sv | 18 +
 rtl/tick_ctrl_if.sv | 28 ++
 rtl/tick_prescale.sv | 30 +++
 rtl/tick_ctrl.sv | 128 ++++++++++++
 tb/tb_tick_ctrl.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/tick_pkg.sv
// rtl/tick_pkg.sv - shared types and constants for the tick controller
package tick_pkg;

  localparam int unsigned PW_DEF = 16;
  localparam int unsigned RW_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic st_busy(input state_t s);
    return (s != ST_IDLE);
  endfunction

endpackage

// File: rtl/tick_ctrl_if.sv
// rtl/tick_ctrl_if.sv - control/status bundle between a host and tick_ctrl
interface tick_ctrl_if
  import tick_pkg::*;
#(
  parameter int PW = PW_DEF,
  parameter int RW = RW_DEF
);
  logic          start;
  logic          stop;
  logic          pause;
  logic [PW-1:0] period;
  logic [RW-1:0] reps;
  logic          tick;
  logic          done;
  logic          busy;
  logic          err;
  logic [PW-1:0] cnt;

  modport master (
    output start, stop, pause, period, reps,
    input  tick, done, busy, err, cnt
  );

  modport slave (
    input  start, stop, pause, period, reps,
    output tick, done, busy, err, cnt
  );
endinterface

// File: rtl/tick_prescale.sv
// rtl/tick_prescale.sv - PW-bit period counter with clear, enable and terminal count
module tick_prescale #(
  parameter int PW = 16
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic [PW-1:0] i_term,
  output logic [PW-1:0] o_cnt,
  output logic          o_tc
);

  logic [PW-1:0] r_cnt;

  // Clear has priority over enable so a wrap on the terminal count lands on 0.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + PW'(1);
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == i_term);

endmodule

// File: rtl/tick_ctrl.sv
// rtl/tick_ctrl.sv - periodic tick generator with repeat count, pause and abort
module tick_ctrl
  import tick_pkg::*;
#(
  parameter int PW = PW_DEF,
  parameter int RW = RW_DEF
) (
  input logic        clk,
  input logic        reset,
  tick_ctrl_if.slave bus
);

  state_t        r_state;
  state_t        w_next;
  logic [PW-1:0] r_period;
  logic [RW-1:0] r_reps;
  logic [RW-1:0] r_rem;

  logic [PW-1:0] w_term;
  logic [PW-1:0] w_cnt;
  logic          w_tc;
  logic          w_accept;
  logic          w_cnt_clr;
  logic          w_cnt_en;
  logic          w_tick;
  logic          w_done;
  logic          w_err;

  // Terminal count is period-1; a zero period is never latched so the wrap is harmless.
  assign w_term = r_period - PW'(1);

  tick_prescale #(.PW(PW)) u_prescale (
    .i_clk   (clk),
    .i_reset (reset),
    .i_clr   (w_cnt_clr),
    .i_en    (w_cnt_en),
    .i_term  (w_term),
    .o_cnt   (w_cnt),
    .o_tc    (w_tc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and per-cycle strobes; stop beats pause, pause beats advancing.
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_err     = 1'b0;
    w_tick    = 1'b0;
    w_done    = 1'b0;
    w_cnt_en  = 1'b0;
    w_cnt_clr = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.start && !bus.stop) begin
          if (bus.period != '0) begin
            w_accept  = 1'b1;
            w_cnt_clr = 1'b1;
            w_next    = ST_RUN;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (bus.stop) begin
          w_cnt_clr = 1'b1;
          w_next    = ST_IDLE;
        end else if (bus.pause) begin
          w_next = ST_PAUSE;
        end else begin
          w_cnt_en = 1'b1;
          if (w_tc) begin
            w_tick    = 1'b1;
            w_cnt_clr = 1'b1;
            if (r_reps != '0 && r_rem == RW'(1)) begin
              w_next = ST_DONE;
            end
          end
        end
      end
      ST_PAUSE: begin
        if (bus.stop) begin
          w_cnt_clr = 1'b1;
          w_next    = ST_IDLE;
        end else if (!bus.pause) begin
          w_next = ST_RUN;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
        if (!bus.stop) begin
          w_done = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Latched run parameters and the remaining-tick counter (untouched when free-running).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_period <= '0;
      r_reps   <= '0;
      r_rem    <= '0;
    end else if (w_accept) begin
      r_period <= bus.period;
      r_reps   <= bus.reps;
      r_rem    <= bus.reps;
    end else if (w_tick && r_reps != '0) begin
      r_rem <= r_rem - RW'(1);
    end
  end

  assign bus.tick = w_tick & ~reset;
  assign bus.done = w_done & ~reset;
  assign bus.err  = w_err & ~reset;
  assign bus.busy = st_busy(r_state) & ~reset;
  assign bus.cnt  = w_cnt;

endmodule

// File: tb/tb_tick_ctrl.sv
// tb/tb_tick_ctrl.sv - self-checking bench for tick_ctrl
module tb_tick_ctrl;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  tick_ctrl_if #(.PW(16), .RW(8)) bus ();

  tick_ctrl #(.PW(16), .RW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        rst;
    logic        start;
    logic        stop;
    logic        pause;
    logic [15:0] period;
    logic [7:0]  reps;
    logic        tick;
    logic        done;
    logic        busy;
    logic        err;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic rst, st, sp, pa, input logic [15:0] per, input logic [7:0] rp,
                     input logic t, d, b, e, input logic [15:0] c);
    vec_t v;
    v.rst = rst; v.start = st; v.stop = sp; v.pause = pa; v.period = per; v.reps = rp;
    v.tick = t; v.done = d; v.busy = b; v.err = e; v.cnt = c;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, st, sp, pa, input logic [15:0] per, input logic [7:0] rp);
    reset      = rst;
    bus.start  = st;
    bus.stop   = sp;
    bus.pause  = pa;
    bus.period = per;
    bus.reps   = rp;
  endtask

  task automatic check(input string name, input logic t, d, b, e, input logic [15:0] c);
    checks++;
    if ({bus.tick, bus.done, bus.busy, bus.err, bus.cnt} !== {t, d, b, e, c}) begin
      errors++;
      $display("FAIL %s: got tick=%b done=%b busy=%b err=%b cnt=%0d, want tick=%b done=%b busy=%b err=%b cnt=%0d",
               name, bus.tick, bus.done, bus.busy, bus.err, bus.cnt, t, d, b, e, c);
    end
  endtask

  // One cycle: inputs set just after a rising edge, outputs checked at the falling edge.
  task automatic cyc(input string name, input logic rst, st, sp, pa, input logic [15:0] per,
                     input logic [7:0] rp, input logic t, d, b, e, input logic [15:0] c);
    drive(rst, st, sp, pa, per, rp);
    @(negedge clk);
    check(name, t, d, b, e, c);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 8'd0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 8'd0);
  endtask

  initial begin
    logic [15:0] c;

    // Reset and basic IDLE behaviour.
    add(1, 0, 0, 0, 16'd0, 8'd0, 0, 0, 0, 0, 16'd0);
    add(0, 0, 0, 0, 16'd0, 8'd0, 0, 0, 0, 0, 16'd0);
    // period=4 reps=3: ticks in cycles 4, 8, 12; done in 13; idle in 14.
    add(0, 1, 0, 0, 16'd4, 8'd3, 0, 0, 0, 0, 16'd0);
    for (int k = 1; k <= 12; k++) begin
      c = 16'((k - 1) % 4);
      add(0, 0, 0, 0, 16'd4, 8'd3, (c == 16'd3), 0, 1, 0, c);
    end
    add(0, 0, 0, 0, 16'd4, 8'd3, 0, 1, 1, 0, 16'd0);
    add(0, 0, 0, 0, 16'd4, 8'd3, 0, 0, 0, 0, 16'd0);
    // Zero period rejected with err, stays idle.
    add(0, 1, 0, 0, 16'd0, 8'd2, 0, 0, 0, 1, 16'd0);
    add(0, 0, 0, 0, 16'd0, 8'd2, 0, 0, 0, 0, 16'd0);
    // Stop wins over start: no start, no err.
    add(0, 1, 1, 0, 16'd4, 8'd3, 0, 0, 0, 0, 16'd0);
    add(0, 0, 0, 0, 16'd4, 8'd3, 0, 0, 0, 0, 16'd0);
    add(0, 1, 1, 0, 16'd0, 8'd3, 0, 0, 0, 0, 16'd0);
    add(0, 0, 0, 0, 16'd0, 8'd3, 0, 0, 0, 0, 16'd0);

    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 8'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      cyc($sformatf("tbl[%0d]", i), vecs[i].rst, vecs[i].start, vecs[i].stop, vecs[i].pause,
          vecs[i].period, vecs[i].reps, vecs[i].tick, vecs[i].done, vecs[i].busy,
          vecs[i].err, vecs[i].cnt);
    end

    // Pause held in cycles 3-6 with cnt=2; ticks resume at cycle 10, then every 5.
    do_reset();
    cyc("pause c0", 0, 1, 0, 0, 16'd5, 8'd0, 0, 0, 0, 0, 16'd0);
    for (int k = 1; k <= 2; k++)
      cyc($sformatf("pause c%0d", k), 0, 0, 0, 0, 16'd5, 8'd0, 0, 0, 1, 0, 16'(k - 1));
    for (int k = 3; k <= 6; k++)
      cyc($sformatf("pause c%0d", k), 0, 0, 0, 1, 16'd5, 8'd0, 0, 0, 1, 0, 16'd2);
    cyc("pause c7", 0, 0, 0, 0, 16'd5, 8'd0, 0, 0, 1, 0, 16'd2);
    for (int k = 8; k <= 21; k++) begin
      c = 16'((k - 6) % 5);
      cyc($sformatf("pause c%0d", k), 0, 0, 0, 0, 16'd5, 8'd0, (c == 16'd4), 0, 1, 0, c);
    end
    cyc("pause stop", 0, 0, 1, 0, 16'd5, 8'd0, 0, 0, 1, 0, 16'd1);
    cyc("pause idle", 0, 0, 0, 0, 16'd5, 8'd0, 0, 0, 0, 0, 16'd0);

    // Stop on the cycle of the first tick: tick suppressed, no done, idle next.
    do_reset();
    cyc("stop c0", 0, 1, 0, 0, 16'd3, 8'd2, 0, 0, 0, 0, 16'd0);
    cyc("stop c1", 0, 0, 0, 0, 16'd3, 8'd2, 0, 0, 1, 0, 16'd0);
    cyc("stop c2", 0, 0, 0, 0, 16'd3, 8'd2, 0, 0, 1, 0, 16'd1);
    cyc("stop c3", 0, 0, 1, 0, 16'd3, 8'd2, 0, 0, 1, 0, 16'd2);
    cyc("stop c4", 0, 0, 0, 0, 16'd3, 8'd2, 0, 0, 0, 0, 16'd0);
    cyc("stop c5", 0, 0, 0, 0, 16'd3, 8'd2, 0, 0, 0, 0, 16'd0);

    // period=1 reps=4: four back-to-back ticks, mid-run start ignored, then done.
    do_reset();
    cyc("p1 c0", 0, 1, 0, 0, 16'd1, 8'd4, 0, 0, 0, 0, 16'd0);
    cyc("p1 c1", 0, 0, 0, 0, 16'd1, 8'd4, 1, 0, 1, 0, 16'd0);
    cyc("p1 c2", 0, 1, 0, 0, 16'd7, 8'd9, 1, 0, 1, 0, 16'd0);
    cyc("p1 c3", 0, 0, 0, 0, 16'd7, 8'd9, 1, 0, 1, 0, 16'd0);
    cyc("p1 c4", 0, 0, 0, 0, 16'd7, 8'd9, 1, 0, 1, 0, 16'd0);
    cyc("p1 c5", 0, 0, 0, 0, 16'd7, 8'd9, 0, 1, 1, 0, 16'd0);
    cyc("p1 c6", 0, 0, 0, 0, 16'd7, 8'd9, 0, 0, 0, 0, 16'd0);

    // Reset during RUN at cnt=7: cleared next edge, no done or tick.
    do_reset();
    cyc("rst c0", 0, 1, 0, 0, 16'd20, 8'd0, 0, 0, 0, 0, 16'd0);
    for (int k = 1; k <= 7; k++)
      cyc($sformatf("rst c%0d", k), 0, 0, 0, 0, 16'd20, 8'd0, 0, 0, 1, 0, 16'(k - 1));
    cyc("rst c8", 1, 0, 0, 0, 16'd20, 8'd0, 0, 0, 0, 0, 16'd7);
    cyc("rst c9", 0, 0, 0, 0, 16'd20, 8'd0, 0, 0, 0, 0, 16'd0);
    cyc("rst c10", 0, 0, 0, 0, 16'd20, 8'd0, 0, 0, 0, 0, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
